// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable integer clock dividers with phase offset, per-channel
// enable, aligned strobes and a lock flag. Optional `sync` realign input: CLK_DIV_SYNC_EN.
module clk_div_bank #(
    parameter int                N_CH        = 4,
    parameter int                DIV_W       = 8,
    parameter int                DIV_DEFAULT = 4,
    parameter logic [N_CH-1:0]   EN_DEFAULT  = {N_CH{1'b1}},
    parameter int                LOCK_CYC    = 64,
    parameter int                CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    output logic              cfg_err,
    output logic [N_CH-1:0]   outclk,
    output logic [N_CH-1:0]   outstb,
    output logic              locked
);

    localparam int                LCK_W   = $clog2(LOCK_CYC + 1);
    localparam logic [LCK_W-1:0]  LCK_MAX = LCK_W'(LOCK_CYC);
    localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] r_div   [N_CH];
    logic [DIV_W-1:0] r_phase [N_CH];
    logic [DIV_W-1:0] r_cnt   [N_CH];
    logic [N_CH-1:0]  r_en;
    logic [N_CH-1:0]  r_outclk;
    logic [N_CH-1:0]  r_outstb;
    logic             r_err;
    logic [LCK_W-1:0] r_lock;
    logic             r_locked;
    logic             r_run;

    logic [DIV_W-1:0] w_div_nxt   [N_CH];
    logic [DIV_W-1:0] w_phase_nxt [N_CH];
    logic [DIV_W-1:0] w_cnt_nxt   [N_CH];
    logic [N_CH-1:0]  w_en_nxt;
    logic [N_CH-1:0]  w_clk_nxt;
    logic [N_CH-1:0]  w_stb_nxt;
    logic             w_acc;
    logic             w_hit;
    logic             w_sync;
    logic [LCK_W-1:0] w_lock_nxt;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Outputs are derived from the next-state counter so they register cleanly
    // alongside it; r_run holds every channel at cnt=0 on the first edge out of reset.
    always_comb begin
        w_acc = cfg_wr && (32'(cfg_ch) < N_CH) && (cfg_div >= DIV_W'(2))
                && (cfg_phase < cfg_div);
        w_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_hit          = w_acc && (32'(cfg_ch) == i);
            w_div_nxt[i]   = w_hit ? cfg_div   : r_div[i];
            w_phase_nxt[i] = w_hit ? cfg_phase : r_phase[i];
            w_en_nxt[i]    = w_hit ? cfg_en    : r_en[i];
            if (!w_en_nxt[i])
                w_cnt_nxt[i] = '0;
            else if (w_hit || w_sync)
                w_cnt_nxt[i] = (w_phase_nxt[i] == '0) ? '0 : w_div_nxt[i] - w_phase_nxt[i];
            else if (!r_run || (r_cnt[i] == r_div[i] - 1'b1))
                w_cnt_nxt[i] = '0;
            else
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            w_clk_nxt[i] = w_en_nxt[i] && (w_cnt_nxt[i] < (w_div_nxt[i] >> 1));
            w_stb_nxt[i] = w_en_nxt[i] && (w_cnt_nxt[i] == '0);
        end
        if (w_acc || w_sync)
            w_lock_nxt = '0;
        else if (r_lock == LCK_MAX)
            w_lock_nxt = r_lock;
        else
            w_lock_nxt = r_lock + 1'b1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_div[i]   <= DIV_RST;
                r_phase[i] <= '0;
                r_cnt[i]   <= '0;
            end
            r_en     <= EN_DEFAULT;
            r_outclk <= '0;
            r_outstb <= '0;
            r_err    <= 1'b0;
            r_lock   <= '0;
            r_locked <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_div[i]   <= w_div_nxt[i];
                r_phase[i] <= w_phase_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_en     <= w_en_nxt;
            r_outclk <= w_clk_nxt;
            r_outstb <= w_stb_nxt;
            r_err    <= cfg_wr && !w_acc;
            r_lock   <= w_lock_nxt;
            r_locked <= (w_lock_nxt == LCK_MAX);
            r_run    <= 1'b1;
        end
    end

    assign cfg_err = r_err;
    assign outclk  = r_outclk;
    assign outstb  = r_outstb;
    assign locked  = r_locked;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (N_CH=4, CH_W=3 so out-of-range
// channel indices are representable). Sync checks are compiled with CLK_DIV_SYNC_EN.
module tb_clk_div_bank;

    localparam int N_CH = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_phase = '0;
    logic       cfg_en = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    logic       sync = 1'b0;
`endif
    logic       cfg_err;
    logic [3:0] outclk;
    logic [3:0] outstb;
    logic       locked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lk = 0;
    int m_n  [N_CH];
    int m_p  [N_CH];
    int m_t0 [N_CH];
    bit m_en [N_CH];

    clk_div_bank #(.N_CH(N_CH), .CH_W(3)) dut (
        .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
`ifdef CLK_DIV_SYNC_EN
        .sync(sync),
`endif
        .cfg_err(cfg_err), .outclk(outclk), .outstb(outstb), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Channel phase within its period: cycle t0 is a strobe cycle.
    function automatic int ph(input int i);
        int d;
        d = (cyc - m_t0[i]) % m_n[i];
        if (d < 0) d += m_n[i];
        return d;
    endfunction

    task automatic check_all(input string tag, input logic err_exp);
        logic [3:0] es, ec;
        es = '0;
        ec = '0;
        for (int i = 0; i < N_CH; i++) begin
            es[i] = m_en[i] && (ph(i) == 0);
            ec[i] = m_en[i] && (ph(i) < m_n[i] / 2);
        end
        chk({tag, "_stb"}, outstb, es);
        chk({tag, "_clk"}, outclk, ec);
        chk({tag, "_lock"}, {3'b0, locked}, {3'b0, (cyc - lk) >= 64});
        chk({tag, "_err"}, {3'b0, cfg_err}, {3'b0, err_exp});
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            tick();
            check_all(tag, 1'b0);
        end
    endtask

    task automatic model_release();
        for (int i = 0; i < N_CH; i++) begin
            m_n[i] = 4; m_p[i] = 0; m_t0[i] = cyc; m_en[i] = 1'b1;
        end
        lk = cyc - 1;
    endtask

    task automatic wr(input int ch, input int n, input int p, input bit en, input bit ok,
                      input string tag);
        cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = 8'(n); cfg_phase = 8'(p); cfg_en = en;
        tick();
        cfg_wr = 1'b0;
        if (ok) begin
            m_n[ch] = n; m_p[ch] = p; m_en[ch] = en; m_t0[ch] = cyc + p;
            lk = cyc;
        end
        check_all(tag, !ok);
        tick();
        check_all({tag, "_next"}, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stb"}, outstb, 4'b0000);
        chk({tag, "_clk"}, outclk, 4'b0000);
        chk({tag, "_lock"}, {3'b0, locked}, 4'b0000);
        chk({tag, "_err"}, {3'b0, cfg_err}, 4'b0000);
    endtask

    initial begin
        // Reset and release: aligned default channels, lock after 64 cycles
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        model_release();
        chk("first_stb", outstb, 4'b1111);
        chk("first_clk", outclk, 4'b1111);
        check_all("release", 1'b0);
        run(70, "default");

        // Ratio 5, phase 0 on ch1; lock drops and recovers
        wr(1, 5, 0, 1'b1, 1'b1, "wr_ch1_n5");
        run(70, "ch1_n5");

        // Ratio 6, phase 2 on ch2
        wr(2, 6, 2, 1'b1, 1'b1, "wr_ch2_n6p2");
        run(70, "ch2_n6p2");

        // Rejected writes while locked
        wr(0, 1, 0, 1'b1, 1'b0, "rej_n1");
        wr(0, 5, 5, 1'b1, 1'b0, "rej_p5n5");
        wr(7, 4, 0, 1'b1, 1'b0, "rej_ch7");
        run(5, "after_rej");

        // Disable ch0, then re-enable at ratio 3
        wr(0, 4, 0, 1'b0, 1'b1, "dis_ch0");
        run(10, "ch0_off");
        wr(0, 3, 0, 1'b1, 1'b1, "en_ch0_n3");
        run(12, "ch0_n3");

        // Maximum ratio, plain and with maximum phase
        wr(3, 255, 0, 1'b1, 1'b1, "wr_ch3_n255");
        run(520, "ch3_n255");
        wr(3, 255, 254, 1'b1, 1'b1, "wr_ch3_p254");
        run(300, "ch3_p254");

        // Write on the cycle the lock counter would saturate keeps locked low
        wr(1, 7, 3, 1'b1, 1'b1, "wr_pre_sat");
        run(62, "pre_sat");
        wr(1, 5, 0, 1'b1, 1'b1, "wr_at_sat");
        run(70, "post_sat");

        // Reset coincident with a write: reset values win
        rst = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd9; cfg_phase = 8'd0; cfg_en = 1'b1;
        tick();
        chk_reset("rst_wr");
        rst = 1'b0;
        cfg_wr = 1'b0;
        tick();
        model_release();
        check_all("rst_wr_release", 1'b0);
        run(20, "rst_wr_after");

`ifdef CLK_DIV_SYNC_EN
        // Sync realigns channels at ratios 4/6/8
        wr(1, 6, 0, 1'b1, 1'b1, "s_ch1");
        wr(2, 8, 0, 1'b1, 1'b1, "s_ch2");
        wr(3, 8, 0, 1'b1, 1'b1, "s_ch3");
        run(3, "pre_sync");
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i < N_CH; i++) m_t0[i] = cyc + m_p[i];
        lk = cyc;
        chk("sync_stb", outstb, 4'b1111);
        check_all("sync", 1'b0);
        run(30, "post_sync");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
